// File: rtl/lfsr_prbs_burst_ctrl.sv
`timescale 1ns/1ps
// lfsr_prbs_burst_ctrl
// Burst sequencer for one external lfsr_prbs_gen. Accepts burst commands,
// drives the generator reset/enable, and presents the PRBS words as an
// AXI-stream master with backpressure, tlast framing and an inter-burst gap.
//
// Optional feature macro: LFSR_PRBS_ERR_INJECT_EN
//   When defined, adds i_err_inject. A pulse arms a one-shot flag. The next
//   accepted beat has tdata[0] inverted, and the flag clears on that beat.
//   Further pulses while the flag is armed are ignored.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_len, i_cmd_reseed
//                       burst command (length minus one, optional reseed)
//   o_gen_rst           generator reset, active-high, registered
//   o_gen_enable        generator advance, asserted only on a stream handshake
//   i_gen_data          generator output word (registered in the generator)
//   o_m_axis_*          AXI-stream master (tdata/tvalid/tready/tlast)
//   o_busy              high whenever the FSM is not idle
//   o_burst_done        one-cycle pulse after the final beat is accepted
//   i_err_inject        only with LFSR_PRBS_ERR_INJECT_EN
//
// state    | meaning
// S_IDLE   | ready for a command (cmd_ready high once out of reset)
// S_RESEED | gen_rst high for one cycle before streaming
// S_STREAM | presenting words; count tracks beats remaining minus one
// S_GAP    | idle spacing after a burst, GAP_CYCLES long
module lfsr_prbs_burst_ctrl #(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_cmd_reseed,
  output logic              o_gen_rst,
  output logic              o_gen_enable,
  input  logic [DATA_W-1:0] i_gen_data,
  output logic [DATA_W-1:0] o_m_axis_tdata,
  output logic              o_m_axis_tvalid,
  input  logic              i_m_axis_tready,
  output logic              o_m_axis_tlast,
  output logic              o_busy,
  output logic              o_burst_done
`ifdef LFSR_PRBS_ERR_INJECT_EN
  ,
  input  logic              i_err_inject
`endif
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESEED = 2'd1,
    S_STREAM = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_count;
  logic [GAP_W-1:0]   r_gap;
  logic               r_gen_rst;
  logic               r_cmd_ready;
  logic               r_tvalid;
  logic               r_tlast;
  logic               r_done;
  logic               w_beat;
  logic [DATA_W-1:0]  w_flip;

  assign w_beat = r_tvalid & i_m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_gap       <= '0;
      r_gen_rst   <= 1'b1;
      r_cmd_ready <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_gen_rst <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (r_cmd_ready && i_cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_count     <= i_cmd_len;
            r_tlast     <= (i_cmd_len == '0);
            if (i_cmd_reseed) begin
              r_state   <= S_RESEED;
              r_gen_rst <= 1'b1;
            end else begin
              r_state  <= S_STREAM;
              r_tvalid <= 1'b1;
            end
          end
        end
        S_RESEED: begin
          // Generator reloads its seed on this edge; its first word is
          // therefore valid on the stream in the next cycle.
          r_state  <= S_STREAM;
          r_tvalid <= 1'b1;
        end
        S_STREAM: begin
          if (w_beat) begin
            if (r_tlast) begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_done   <= 1'b1;
              if (GAP_CYCLES > 0) begin
                r_state <= S_GAP;
                r_gap   <= GAP_W'(GAP_CYCLES);
              end else begin
                r_state     <= S_IDLE;
                r_cmd_ready <= 1'b1;
              end
            end else begin
              // Count stops at zero on the final beat, so a full-range
              // length never wraps mid-burst.
              r_count <= r_count - 1'b1;
              r_tlast <= (r_count == LEN_W'(1));
            end
          end
        end
        S_GAP: begin
          if (r_gap <= GAP_W'(1)) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LFSR_PRBS_ERR_INJECT_EN
  logic r_err_armed;

  // Consumption wins over a new pulse, so a pulse on the consuming beat is
  // ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_armed <= 1'b0;
    end else if (w_beat && r_err_armed) begin
      r_err_armed <= 1'b0;
    end else if (i_err_inject) begin
      r_err_armed <= 1'b1;
    end
  end

  assign w_flip = {{(DATA_W-1){1'b0}}, r_err_armed};
`else
  assign w_flip = '0;
`endif

  assign o_cmd_ready     = r_cmd_ready;
  assign o_gen_rst       = r_gen_rst;
  assign o_gen_enable    = w_beat;
  assign o_m_axis_tdata  = i_gen_data ^ w_flip;
  assign o_m_axis_tvalid = r_tvalid;
  assign o_m_axis_tlast  = r_tlast;
  assign o_busy          = (r_state != S_IDLE);
  assign o_burst_done    = r_done;

endmodule
